pipe_stall_ctrl: RTL and testbench
==================================

# pipe_stall_ctrl

Parametrised pipeline stall/flush controller for the multi-stage MIPS core; successor to the fixed single-stall-point control block. It combines the decode-stage data-hazard stall request with an internal multiply/divide busy counter and an exception flush request. From these it produces the PC write enable and per-pipeline-register enable/clear vectors. It sits beside the hazard unit and drives every inter-stage register plus the PC.

## Interface

Parameters
- NSTAGE, 5: number of pipeline stages. There are NSTAGE-1 inter-stage registers; register i sits between stage i and stage i+1 (i=0 is F/D).
- STALL_STAGE, 1: index of the stage that is held on a stall. Must be 1 .. NSTAGE-2.
- MULT_CYCLES, 5: busy cycles after a multiply start. Must be ≥1.
- DIV_CYCLES, 10: busy cycles after a divide start. Must be ≥1.

Ports
- clk, input, 1: clock, rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- hazard_stall, input, 1: data-hazard stall request from the hazard unit.
- md_start, input, 1: mult/div instruction issuing in E this cycle.
- md_is_div, input, 1: qualifies md_start. 1 = divide, 0 = multiply.
- md_use, input, 1: instruction in the held stage needs the MD unit (mult/div/mfhi/mflo/mthi/mtlo).
- flush_req, input, 1: exception/eret flush.
- pc_en, output, 1: PC write enable.
- stage_en, output, NSTAGE-1: per-register write enable.
- stage_clr, output, NSTAGE-1: per-register synchronous clear (inserts a bubble).
- md_busy, output, 1: MD unit busy.
- stall, output, 1: effective stall this cycle.
- stall_cnt, output, 32: stall-cycle count. Present only with PIPE_STALL_PERF_EN.
- perf_clr, input, 1: clears stall_cnt. Present only with PIPE_STALL_PERF_EN.

## Operation

MD counter
- md_cnt is an unsigned register of width $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).
- md_busy = (md_cnt != 0).
- If md_start=1 and md_busy=0: load DIV_CYCLES when md_is_div=1, else MULT_CYCLES.
- Otherwise, if md_cnt != 0: decrement by 1.
- md_start while md_busy=1 is ignored; the count is not reloaded.
- flush_req does not affect md_cnt; the MD operation completes.

Stall
- stall = ~flush_req & (hazard_stall | (md_use & (md_busy | md_start))).

Output decode (combinational from inputs and md_cnt)
- flush_req=1: pc_en=1, stage_en all 1, stage_clr all 1. Flush overrides stall.
- stall=1:
  - pc_en=0.
  - stage_en[i]=0 for i < STALL_STAGE; all other bits 1.
  - stage_clr[STALL_STAGE-1+1]=1, i.e. bit STALL_STAGE (the bubble register); all other bits 0.
- Otherwise: pc_en=1, stage_en all 1, stage_clr all 0.
- stage_en and stage_clr are never both 1 on the same bit, except during flush. Consumers give clr priority over en.

## Timing

- Reset (reset_n=0) clears md_cnt asynchronously.
- Reset outputs with inputs low: pc_en=1, stage_en all 1, stage_clr 0, md_busy=0, stall=0, stall_cnt=0.
- All outputs except md_busy and stall_cnt are combinational, with 0-cycle latency from the inputs.
- md_busy rises the cycle after md_start and stays high for exactly N cycles (N=MULT_CYCLES or DIV_CYCLES).
- An MD-dependent stall covers the md_start cycle plus the N busy cycles, i.e. N+1 cycles. The held instruction advances in the first cycle with md_busy=0.
- Reset asserted mid-operation aborts the count immediately. After release, md_busy=0.
- md_start and the final decrement in the same cycle: the counter reaches 0, then the new start is accepted the next cycle, since busy is sampled before update. This case does not occur because the issuing instruction is stalled.

## Configuration

- PIPE_STALL_PERF_EN defined:
  - stall_cnt and perf_clr ports exist.
  - stall_cnt increments on each rising clk edge with stall=1 and saturates at 32'hFFFFFFFF.
  - perf_clr=1 clears it to 0 on the next edge and takes priority over increment.
  - reset_n clears it asynchronously.
- PIPE_STALL_PERF_EN undefined: ports and counter are absent; the remaining behaviour is identical.

## Test plan

All scenarios use the defaults (NSTAGE=5, STALL_STAGE=1, MULT_CYCLES=5, DIV_CYCLES=10).

- Reset, all inputs 0 -> pc_en=1, stage_en=4'b1111, stage_clr=4'b0000, md_busy=0.
- hazard_stall=1 for 2 cycles -> both cycles pc_en=0, stage_en=4'b1110, stage_clr=4'b0010. Third cycle returns to the idle values.
- md_start=1, md_is_div=0 at cycle t with md_use=1 held -> stall=1 for cycles t..t+5, md_busy=1 for t+1..t+5, stall=0 at t+6.
- md_start=1, md_is_div=1 with md_use=0 -> md_busy high for exactly 10 cycles, stall never asserted, pc_en stays 1.
- flush_req=1 at the 4th busy cycle of a divide, with hazard_stall=1 -> pc_en=1, stage_clr=4'b1111, stall=0, md_busy remains high and ends at its original cycle.
- (PIPE_STALL_PERF_EN) 3 hazard cycles -> stall_cnt=3; perf_clr pulse -> stall_cnt=0 next cycle; a flush cycle does not increment.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: merges hazard stalls, a mult/div busy counter and exception flush.
// Optional stall-cycle performance counter is enabled with the PIPE_STALL_PERF_EN macro.
module pipe_stall_ctrl #(
  parameter int NSTAGE      = 5,
  parameter int STALL_STAGE = 1,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              hazard_stall,
  input  logic              md_start,
  input  logic              md_is_div,
  input  logic              md_use,
  input  logic              flush_req,
  output logic              pc_en,
  output logic [NSTAGE-2:0] stage_en,
  output logic [NSTAGE-2:0] stage_clr,
  output logic              md_busy,
  output logic              stall
`ifdef PIPE_STALL_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  input  logic              perf_clr
`endif
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES);

  // Registers below the held stage freeze; the one just after it takes a bubble.
  localparam logic [NSTAGE-2:0] STALL_EN  = ~((NSTAGE-1)'((1 << STALL_STAGE) - 1));
  localparam logic [NSTAGE-2:0] STALL_CLR = (NSTAGE-1)'(1 << STALL_STAGE);

  logic [CW-1:0] md_cnt;
  logic [CW-1:0] md_cnt_nxt;

  assign md_busy = (md_cnt != '0);

  // A start while busy is dropped; flush never touches the count.
  always_comb begin
    md_cnt_nxt = md_cnt;
    if (md_start && !md_busy) begin
      md_cnt_nxt = md_is_div ? DIV_LD : MULT_LD;
    end else if (md_cnt != '0) begin
      md_cnt_nxt = md_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      md_cnt <= '0;
    end else begin
      md_cnt <= md_cnt_nxt;
    end
  end

  assign stall = ~flush_req & (hazard_stall | (md_use & (md_busy | md_start)));

  always_comb begin
    pc_en     = 1'b1;
    stage_en  = '1;
    stage_clr = '0;
    if (flush_req) begin
      stage_clr = '1;
    end else if (stall) begin
      pc_en     = 1'b0;
      stage_en  = STALL_EN;
      stage_clr = STALL_CLR;
    end
  end

`ifdef PIPE_STALL_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (perf_clr) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed scenarios with literal expectations, then random traffic
// checked every cycle against a cycle-indexed behavioural model.
module tb_pipe_stall_ctrl;
  localparam int NSTAGE      = 5;
  localparam int STALL_STAGE = 1;
  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;
  localparam int NR          = NSTAGE - 1;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n = 1'b0;
  logic          hazard_stall = 1'b0, md_start = 1'b0, md_is_div = 1'b0;
  logic          md_use = 1'b0, flush_req = 1'b0;
  logic          pc_en, md_busy, stall;
  logic [NR-1:0] stage_en, stage_clr;
`ifdef PIPE_STALL_PERF_EN
  logic          perf_clr = 1'b0;
  logic [31:0]   stall_cnt;
`endif

  pipe_stall_ctrl #(
    .NSTAGE(NSTAGE), .STALL_STAGE(STALL_STAGE),
    .MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)
  ) dut (
    .clk(clk), .reset_n(reset_n), .hazard_stall(hazard_stall),
    .md_start(md_start), .md_is_div(md_is_div), .md_use(md_use),
    .flush_req(flush_req), .pc_en(pc_en), .stage_en(stage_en),
    .stage_clr(stage_clr), .md_busy(md_busy), .stall(stall)
`ifdef PIPE_STALL_PERF_EN
    , .stall_cnt(stall_cnt), .perf_clr(perf_clr)
`endif
  );

  int errors = 0;
  int checks = 0;

  // model: the MD unit is busy on cycles start+1 .. busy_until
  int          cyc = 0;
  int          busy_until = -1;
  logic [31:0] cnt_m = 32'd0;

  function automatic logic busy_e();
    return reset_n && (cyc <= busy_until);
  endfunction

  function automatic logic stall_e();
    return !flush_req && (hazard_stall || (md_use && (busy_e() || md_start)));
  endfunction

  function automatic logic [NR-1:0] en_e();
    logic [NR-1:0] v;
    v = '1;
    if (!flush_req && stall_e()) begin
      for (int i = 0; i < NR; i++) v[i] = (i >= STALL_STAGE);
    end
    return v;
  endfunction

  function automatic logic [NR-1:0] clr_e();
    logic [NR-1:0] v;
    v = '0;
    if (flush_req) v = '1;
    else if (stall_e()) v[STALL_STAGE] = 1'b1;
    return v;
  endfunction

  always @(posedge clk) begin
    if (reset_n) begin
      if (md_start && !busy_e())
        busy_until = cyc + (md_is_div ? DIV_CYCLES : MULT_CYCLES);
`ifdef PIPE_STALL_PERF_EN
      if (perf_clr) cnt_m = 32'd0;
      else if (stall_e() && cnt_m != 32'hFFFF_FFFF) cnt_m = cnt_m + 32'd1;
`endif
    end
    cyc = cyc + 1;
  end

  always @(negedge reset_n) begin
    busy_until = -1;
    cnt_m      = 32'd0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // scoreboard compare, every cycle, mid low phase
  always @(negedge clk) begin
    #2;
    chk("pc_en",     32'(pc_en),     32'(!stall_e()));
    chk("stage_en",  32'(stage_en),  32'(en_e()));
    chk("stage_clr", 32'(stage_clr), 32'(clr_e()));
    chk("md_busy",   32'(md_busy),   32'(busy_e()));
    chk("stall",     32'(stall),     32'(stall_e()));
`ifdef PIPE_STALL_PERF_EN
    chk("stall_cnt", stall_cnt, cnt_m);
`endif
  end

  // driver
  task automatic step(input logic hs, input logic ms, input logic dv,
                      input logic us, input logic fl, input logic pc);
    @(negedge clk);
    reset_n      = 1'b1;
    hazard_stall = hs;
    md_start     = ms;
    md_is_div    = dv;
    md_use       = us;
    flush_req    = fl;
`ifdef PIPE_STALL_PERF_EN
    perf_clr     = pc;
`else
    if (pc) begin end
`endif
    #3;
  endtask

  int n;

  initial begin
    repeat (2) @(negedge clk);

    step(0, 0, 0, 0, 0, 0);
    chk("rst_pc_en", 32'(pc_en), 32'd1);
    chk("rst_stage_en", 32'(stage_en), 32'b1111);
    chk("rst_stage_clr", 32'(stage_clr), 32'b0000);
    chk("rst_md_busy", 32'(md_busy), 32'd0);

    repeat (2) begin
      step(1, 0, 0, 0, 0, 0);
      chk("hz_pc_en", 32'(pc_en), 32'd0);
      chk("hz_stage_en", 32'(stage_en), 32'b1110);
      chk("hz_stage_clr", 32'(stage_clr), 32'b0010);
    end
    step(0, 0, 0, 0, 0, 0);
    chk("hz_end_en", 32'(stage_en), 32'b1111);
    chk("hz_end_clr", 32'(stage_clr), 32'b0000);

    step(0, 1, 0, 1, 0, 0);
    chk("mul_t_stall", 32'(stall), 32'd1);
    chk("mul_t_busy", 32'(md_busy), 32'd0);
    repeat (5) begin
      step(0, 0, 0, 1, 0, 0);
      chk("mul_stall", 32'(stall), 32'd1);
      chk("mul_busy", 32'(md_busy), 32'd1);
    end
    step(0, 0, 0, 1, 0, 0);
    chk("mul_t6_stall", 32'(stall), 32'd0);
    chk("mul_t6_busy", 32'(md_busy), 32'd0);

    step(0, 1, 1, 0, 0, 0);
    chk("div_start_pc_en", 32'(pc_en), 32'd1);
    n = 0;
    repeat (12) begin
      step(0, 0, 0, 0, 0, 0);
      if (md_busy) n++;
      chk("div_pc_en", 32'(pc_en), 32'd1);
    end
    chk("div_busy_len", n, 10);

    step(0, 1, 1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0);
    chk("fl_pc_en", 32'(pc_en), 32'd1);
    chk("fl_stage_clr", 32'(stage_clr), 32'b1111);
    chk("fl_stall", 32'(stall), 32'd0);
    chk("fl_md_busy", 32'(md_busy), 32'd1);
    n = 0;
    repeat (10) begin
      step(0, 0, 0, 0, 0, 0);
      if (md_busy) n++;
    end
    chk("fl_busy_rest", n, 6);

`ifdef PIPE_STALL_PERF_EN
    step(0, 0, 0, 0, 0, 1);
    repeat (3) step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("perf_three", stall_cnt, 32'd3);
    step(1, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("perf_flush", stall_cnt, 32'd3);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("perf_clr", stall_cnt, 32'd0);
`endif

    // random traffic, including occasional asynchronous reset
    repeat (3000) begin
      @(negedge clk);
      reset_n      = ($urandom_range(0, 199) != 0);
      hazard_stall = ($urandom_range(0, 3) == 0);
      md_start     = ($urandom_range(0, 5) == 0);
      md_is_div    = $urandom_range(0, 1) == 1;
      md_use       = $urandom_range(0, 1) == 1;
      flush_req    = ($urandom_range(0, 11) == 0);
`ifdef PIPE_STALL_PERF_EN
      perf_clr     = ($urandom_range(0, 39) == 0);
`endif
      #3;
    end

    step(0, 0, 0, 0, 0, 0);
    #10;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
